pll_hdmi_reconf: RTL and testbench
==================================

PLL_HDMI_RECONF -- requirements
Module: pll_hdmi_reconf

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 65535: clk cycles to wait for PLL lock before flagging an error.
REQ-002 Parameter RETRY_MAX, default 3: number of full reprogram attempts after a readback or lock failure before ERROR.
REQ-003 clk  input  1  controller clock; the same net also drives the PLL dynamic-port clock (mdclk).
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mode  input  2  requested video timing: 0 = PAL 50 Hz, 1 = NTSC 60 Hz, 2 = VGA 60 Hz, 3 = reserved (treated as 0).
REQ-006 start  input  1  single-cycle pulse that forces reprogramming even when mode is unchanged.
REQ-007 pll_lock  input  1  PLL lock output; asynchronous to clk.
REQ-008 mdrdo  input  8  PLL dynamic-port read data.
REQ-009 pll_reset  output  1  drives the PLL reset input.
REQ-010 mdopc  output  2  dynamic-port opcode: 00 NOP, 01 write, 10 read, 11 load address from mdwdi.
REQ-011 mdainc  output  1  dynamic-port address-increment strobe; held 0 by this block.
REQ-012 mdwdi  output  8  dynamic-port write data or address.
REQ-013 busy  output  1  high while a reprogram sequence is in progress.
REQ-014 done  output  1  one-cycle pulse when the PLL has locked after a sequence completes.
REQ-015 error  output  1  sticky failure flag; cleared when the next sequence starts.
REQ-016 cur_mode  output  2  mode of the most recent successful programming.

Function
REQ-017 pll_lock SHALL pass through a 2-flop synchronizer before any use.
REQ-018 Internal ROM SHALL hold 4 {addr,data} entries per mode:
- mode0: {00,01} {01,01} {02,0A} {03,02}
- mode1: {00,01} {01,01} {02,0C} {03,02}
- mode2: {00,02} {01,01} {02,0E} {03,02}
REQ-019 States: IDLE, ASSERT_RST, SET_ADDR, WRITE, READ, READ_WAIT, CHECK, RELEASE, WAIT_LOCK, ERROR.
REQ-020 Sequence trigger: in IDLE or ERROR, a start pulse or (mode != cur_mode) SHALL latch mode into a working register and enter ASSERT_RST.
- error clears on entry to ASSERT_RST.
- busy rises the same cycle as the state change.
REQ-021 ASSERT_RST SHALL assert pll_reset, wait 4 cycles, clear the entry index, then go to SET_ADDR.
REQ-022 Opcode timing: every non-NOP opcode SHALL be driven for exactly one cycle; mdopc=00 in all other cycles.
REQ-023 Per-entry order: SET_ADDR (opc 11, mdwdi=addr) -> WRITE (opc 01, mdwdi=data) -> SET_ADDR again -> READ (opc 10) -> READ_WAIT for 2 cycles -> CHECK.
REQ-024 CHECK outcome:
- mdrdo == data and index < 3: increment index, go to SET_ADDR.
- mdrdo == data and index == 3: go to RELEASE.
- mismatch: go to retry handling (REQ-027).
REQ-025 RELEASE SHALL deassert pll_reset and clear the lock-timeout counter.
REQ-026 WAIT_LOCK outcome:
- synchronized lock high: pulse done, set cur_mode from the working register, drop busy, go to IDLE.
- counter reaches LOCK_TIMEOUT: go to retry handling (REQ-027).
REQ-027 Retry handling:
- retry count < RETRY_MAX: increment it and go to ASSERT_RST.
- otherwise: go to ERROR with error=1, busy=0, pll_reset=0.
REQ-028 Retry count SHALL clear when a sequence is triggered from IDLE or ERROR.
REQ-029 Triggers while busy SHALL be ignored; a mode change pending at IDLE re-entry triggers a new sequence on the next cycle.
REQ-030 mode=3 SHALL program the mode0 table, and cur_mode SHALL report 0.
REQ-031 The lock-timeout counter SHALL saturate and never wrap.

Reset
REQ-032 Reset SHALL force:
- state=ASSERT_RST, working mode=0, cur_mode=0.
- pll_reset=1, mdopc=00, mdainc=0, mdwdi=00.
- busy=1, done=0, error=0, retry count=0.
The block therefore programs mode0 automatically after reset.
REQ-033 Reset asserted mid-sequence SHALL abort immediately to the REQ-032 state, with no partial opcode cycle.

Verification
REQ-034 Release reset with mode=0 and a PLL model that echoes writes and locks 100 cycles after reset deasserts -> 16 opcodes in order 11/01/11/10 per entry; done pulses once; cur_mode=0.
REQ-035 Change mode 0->1 while in IDLE -> busy within 1 cycle; entry 2 writes 0C; done pulses; cur_mode=1.
REQ-036 Model returns wrong readback on every attempt -> exactly 4 attempts (pll_reset pulses 4 times), then error=1 and busy=0; a later start clears error.
REQ-037 Lock never asserts, LOCK_TIMEOUT=50 -> each WAIT_LOCK lasts 50 cycles; error=1 after 4 attempts.
REQ-038 Pulse start and change mode during an active sequence, then assert reset at the entry-2 WRITE -> sequence ignores both triggers; reset yields mdopc=00 and pll_reset=1 with busy=1 the same cycle; the restart programs mode0.

Source files
------------

// File: rtl/pll_hdmi_reconf.sv
`default_nettype none
// ============================================================================
// Module   : pll_hdmi_reconf
// Function : Reprograms a video PLL through its dynamic port from a per-mode
//            {addr,data} ROM, verifies each write by readback, waits for lock.
// Revision : 1.0 - initial release
// ============================================================================
module pll_hdmi_reconf #(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int RETRY_MAX    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       start,
    input  logic       pll_lock,
    input  logic [7:0] mdrdo,
    output logic       pll_reset,
    output logic [1:0] mdopc,
    output logic       mdainc,
    output logic [7:0] mdwdi,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [1:0] cur_mode
);

    localparam int LT_W = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam int RT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
    localparam logic [LT_W-1:0] LT_MAX  = LT_W'(LOCK_TIMEOUT);
    localparam logic [LT_W-1:0] LT_LAST = LT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RT_W-1:0] RT_MAX  = RT_W'(RETRY_MAX);

    localparam logic [1:0] OPC_NOP   = 2'b00;
    localparam logic [1:0] OPC_WRITE = 2'b01;
    localparam logic [1:0] OPC_READ  = 2'b10;
    localparam logic [1:0] OPC_ADDR  = 2'b11;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_ASSERT_RST = 4'd1,
        ST_SET_ADDR   = 4'd2,
        ST_WRITE      = 4'd3,
        ST_READ       = 4'd4,
        ST_READ_WAIT  = 4'd5,
        ST_CHECK      = 4'd6,
        ST_RELEASE    = 4'd7,
        ST_WAIT_LOCK  = 4'd8,
        ST_ERROR      = 4'd9
    } state_t;

    // Returns {addr, data}; the working mode is never 3 (mapped on latch)
    function automatic logic [15:0] rom_entry(input logic [1:0] m, input logic [1:0] i);
        logic [15:0] e;
        case ({m, i})
            4'b00_00: e = {8'h00, 8'h01};
            4'b00_01: e = {8'h01, 8'h01};
            4'b00_10: e = {8'h02, 8'h0A};
            4'b00_11: e = {8'h03, 8'h02};
            4'b01_00: e = {8'h00, 8'h01};
            4'b01_01: e = {8'h01, 8'h01};
            4'b01_10: e = {8'h02, 8'h0C};
            4'b01_11: e = {8'h03, 8'h02};
            4'b10_00: e = {8'h00, 8'h02};
            4'b10_01: e = {8'h01, 8'h01};
            4'b10_10: e = {8'h02, 8'h0E};
            4'b10_11: e = {8'h03, 8'h02};
            default:  e = 16'h0000;
        endcase
        return e;
    endfunction

    state_t          state, state_n;
    logic [1:0]      cnt, cnt_n;
    logic [1:0]      idx, idx_n;
    logic            rd_phase, rd_phase_n;
    logic [RT_W-1:0] retry, retry_n;
    logic [LT_W-1:0] lock_cnt, lock_cnt_n;
    logic [1:0]      work_mode, work_mode_n;
    logic [1:0]      cur_mode_n;
    logic            error_n, done_n, busy_n, pll_reset_n;
    logic [1:0]      mdopc_n;
    logic [7:0]      mdwdi_n;
    logic            retry_path;
    logic            trigger;
    logic [1:0]      mode_eff;
    logic [15:0]     cur_entry, nxt_entry;
    logic            lock_meta, lock_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_sync <= lock_meta;
        end
    end

    assign mode_eff  = (mode == 2'd3) ? 2'd0 : mode;
    assign trigger   = start || (mode_eff != cur_mode);
    assign cur_entry = rom_entry(work_mode, idx);
    assign mdainc    = 1'b0;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        rd_phase_n  = rd_phase;
        retry_n     = retry;
        lock_cnt_n  = lock_cnt;
        work_mode_n = work_mode;
        cur_mode_n  = cur_mode;
        error_n     = error;
        done_n      = 1'b0;
        retry_path  = 1'b0;

        case (state)
            ST_IDLE, ST_ERROR: begin
                if (trigger) begin
                    state_n     = ST_ASSERT_RST;
                    work_mode_n = mode_eff;
                    retry_n     = '0;
                    cnt_n       = '0;
                    error_n     = 1'b0;
                end
            end
            ST_ASSERT_RST: begin
                if (cnt == 2'd3) begin
                    state_n    = ST_SET_ADDR;
                    cnt_n      = '0;
                    idx_n      = '0;
                    rd_phase_n = 1'b0;
                end else begin
                    cnt_n = cnt + 2'd1;
                end
            end
            ST_SET_ADDR: state_n = rd_phase ? ST_READ : ST_WRITE;
            ST_WRITE: begin
                state_n    = ST_SET_ADDR;
                rd_phase_n = 1'b1;
            end
            ST_READ: begin
                state_n = ST_READ_WAIT;
                cnt_n   = '0;
            end
            ST_READ_WAIT: begin
                if (cnt == 2'd1) state_n = ST_CHECK;
                else             cnt_n   = cnt + 2'd1;
            end
            ST_CHECK: begin
                if (mdrdo != cur_entry[7:0]) begin
                    retry_path = 1'b1;
                end else if (idx == 2'd3) begin
                    state_n = ST_RELEASE;
                end else begin
                    idx_n      = idx + 2'd1;
                    rd_phase_n = 1'b0;
                    state_n    = ST_SET_ADDR;
                end
            end
            ST_RELEASE: begin
                lock_cnt_n = '0;
                state_n    = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (lock_sync) begin
                    done_n     = 1'b1;
                    cur_mode_n = work_mode;
                    state_n    = ST_IDLE;
                end else if (lock_cnt >= LT_LAST) begin
                    retry_path = 1'b1;
                end else if (lock_cnt != LT_MAX) begin
                    lock_cnt_n = lock_cnt + 1'b1;
                end
            end
            default: state_n = ST_ASSERT_RST;
        endcase

        if (retry_path) begin
            if (retry < RT_MAX) begin
                retry_n = retry + 1'b1;
                cnt_n   = '0;
                state_n = ST_ASSERT_RST;
            end else begin
                error_n = 1'b1;
                state_n = ST_ERROR;
            end
        end
    end

    // Port outputs are registered from the next state so the PLL sees clean levels
    assign nxt_entry = rom_entry(work_mode_n, idx_n);

    always_comb begin
        pll_reset_n = 1'b0;
        busy_n      = 1'b1;
        mdopc_n     = OPC_NOP;
        mdwdi_n     = 8'h00;
        case (state_n)
            ST_IDLE, ST_ERROR: busy_n = 1'b0;
            ST_RELEASE, ST_WAIT_LOCK: pll_reset_n = 1'b0;
            ST_SET_ADDR: begin
                pll_reset_n = 1'b1;
                mdopc_n     = OPC_ADDR;
                mdwdi_n     = nxt_entry[15:8];
            end
            ST_WRITE: begin
                pll_reset_n = 1'b1;
                mdopc_n     = OPC_WRITE;
                mdwdi_n     = nxt_entry[7:0];
            end
            ST_READ: begin
                pll_reset_n = 1'b1;
                mdopc_n     = OPC_READ;
            end
            default: pll_reset_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_ASSERT_RST;
            cnt       <= '0;
            idx       <= '0;
            rd_phase  <= 1'b0;
            retry     <= '0;
            lock_cnt  <= '0;
            work_mode <= 2'd0;
            cur_mode  <= 2'd0;
            error     <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            pll_reset <= 1'b1;
            mdopc     <= OPC_NOP;
            mdwdi     <= 8'h00;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            rd_phase  <= rd_phase_n;
            retry     <= retry_n;
            lock_cnt  <= lock_cnt_n;
            work_mode <= work_mode_n;
            cur_mode  <= cur_mode_n;
            error     <= error_n;
            done      <= done_n;
            busy      <= busy_n;
            pll_reset <= pll_reset_n;
            mdopc     <= mdopc_n;
            mdwdi     <= mdwdi_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_hdmi_reconf.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pll_hdmi_reconf
// Function : Directed self-checking bench; one DUT locks after ~100 cycles,
//            a second (LOCK_TIMEOUT=50) never locks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pll_hdmi_reconf;

    localparam logic [7:0] EXP_DATA [0:2][0:3] = '{
        '{8'h01, 8'h01, 8'h0A, 8'h02},
        '{8'h01, 8'h01, 8'h0C, 8'h02},
        '{8'h02, 8'h01, 8'h0E, 8'h02}};
    localparam logic [1:0] EXP_OPC [0:3] = '{2'b11, 2'b01, 2'b11, 2'b10};

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] mode = 2'd0;
    logic       start = 1'b0;
    logic       bad_rd = 1'b0;

    logic       pll_lock = 1'b0, pll_lock2 = 1'b0;
    logic [7:0] mdrdo = 8'h00, mdrdo2 = 8'h00;
    logic       pll_reset, mdainc, busy, done, error;
    logic [1:0] mdopc, cur_mode;
    logic [7:0] mdwdi;
    logic       pll_reset2, mdainc2, busy2, done2, error2;
    logic [1:0] mdopc2, cur_mode2;
    logic [7:0] mdwdi2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pll_hdmi_reconf u_dut (
        .clk(clk), .reset(reset), .mode(mode), .start(start), .pll_lock(pll_lock),
        .mdrdo(mdrdo), .pll_reset(pll_reset), .mdopc(mdopc), .mdainc(mdainc),
        .mdwdi(mdwdi), .busy(busy), .done(done), .error(error), .cur_mode(cur_mode));

    pll_hdmi_reconf #(.LOCK_TIMEOUT(50), .RETRY_MAX(3)) u_dut_to (
        .clk(clk), .reset(reset), .mode(mode), .start(start), .pll_lock(pll_lock2),
        .mdrdo(mdrdo2), .pll_reset(pll_reset2), .mdopc(mdopc2), .mdainc(mdainc2),
        .mdwdi(mdwdi2), .busy(busy2), .done(done2), .error(error2), .cur_mode(cur_mode2));

    // PLL dynamic-port models: echo writes (optionally corrupted on readback)
    logic [7:0] mem1 [0:3];
    logic [7:0] mem2 [0:3];
    logic [1:0] a1 = 2'd0, a2 = 2'd0;
    int         lc1 = 0;

    always @(posedge clk) begin
        case (mdopc)
            2'b11:   a1 <= mdwdi[1:0];
            2'b01:   mem1[a1] <= mdwdi;
            2'b10:   mdrdo <= bad_rd ? ~mem1[a1] : mem1[a1];
            default: ;
        endcase
        case (mdopc2)
            2'b11:   a2 <= mdwdi2[1:0];
            2'b01:   mem2[a2] <= mdwdi2;
            2'b10:   mdrdo2 <= mem2[a2];
            default: ;
        endcase
        if (pll_reset) begin
            lc1      <= 0;
            pll_lock <= 1'b0;
        end else begin
            if (lc1 < 100) lc1 <= lc1 + 1;
            pll_lock <= (lc1 >= 99);
        end
    end

    // Observation log, sampled on the falling edge
    logic [1:0] log_opc [$];
    logic [7:0] log_wdi [$];
    int         wins [$];
    int         done_cnt = 0, wr_cnt = 0, fall2_cnt = 0, win_len = 0;
    logic       prev_rst2 = 1'b1;

    always @(negedge clk) begin
        if (mdopc != 2'b00) begin
            log_opc.push_back(mdopc);
            log_wdi.push_back(mdwdi);
            if (mdopc == 2'b01) wr_cnt++;
        end
        if (done) done_cnt++;
        if (prev_rst2 && !pll_reset2) fall2_cnt++;
        prev_rst2 = pll_reset2;
        if (!pll_reset2 && busy2) begin
            win_len++;
        end else begin
            if (win_len != 0) wins.push_back(win_len);
            win_len = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        tick(3);
        n_checks++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL rst_pll_reset: got %b want 1", pll_reset); end
        n_checks++; if (mdopc !== 2'b00) begin n_fail++; $display("FAIL rst_mdopc: got %b want 00", mdopc); end
        n_checks++; if (mdainc !== 1'b0) begin n_fail++; $display("FAIL rst_mdainc: got %b want 0", mdainc); end
        n_checks++; if (mdwdi !== 8'h00) begin n_fail++; $display("FAIL rst_mdwdi: got %h want 00", mdwdi); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b want 1", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", error); end
        n_checks++; if (cur_mode !== 2'd0) begin n_fail++; $display("FAIL rst_cur_mode: got %0d want 0", cur_mode); end
    endtask

    task automatic test_power_up();
        int b, d0;
        bit ok;
        b  = log_opc.size();
        d0 = done_cnt;
        reset = 1'b0;
        wait_done(400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL pu_done_timeout: got no done want done"); end
        tick(5);
        n_checks++; if (log_opc.size() - b != 16) begin n_fail++; $display("FAIL pu_op_count: got %0d want 16", log_opc.size() - b); end
        if (log_opc.size() >= b + 16) begin
            for (int k = 0; k < 16; k++) begin
                n_checks++;
                if (log_opc[b+k] !== EXP_OPC[k%4]) begin
                    n_fail++; $display("FAIL pu_opc[%0d]: got %b want %b", k, log_opc[b+k], EXP_OPC[k%4]);
                end
                if (k % 4 == 1) begin
                    n_checks++;
                    if (log_wdi[b+k] !== EXP_DATA[0][k/4]) begin
                        n_fail++; $display("FAIL pu_wdata[%0d]: got %h want %h", k/4, log_wdi[b+k], EXP_DATA[0][k/4]);
                    end
                end else if (k % 4 != 3) begin
                    n_checks++;
                    if (log_wdi[b+k] !== 8'(k/4)) begin
                        n_fail++; $display("FAIL pu_addr[%0d]: got %h want %h", k, log_wdi[b+k], 8'(k/4));
                    end
                end
            end
        end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL pu_done_count: got %0d want 1", done_cnt - d0); end
        n_checks++; if (cur_mode !== 2'd0) begin n_fail++; $display("FAIL pu_cur_mode: got %0d want 0", cur_mode); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL pu_busy: got %b want 0", busy); end
        n_checks++; if (pll_reset !== 1'b0) begin n_fail++; $display("FAIL pu_pll_reset: got %b want 0", pll_reset); end
    endtask

    task automatic test_mode_change();
        int b, d0;
        bit ok;
        b  = log_opc.size();
        d0 = done_cnt;
        mode = 2'd1;
        tick(1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mc_busy_rise: got %b want 1", busy); end
        wait_done(400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL mc_done_timeout: got no done want done"); end
        tick(3);
        n_checks++; if (log_opc.size() - b != 16) begin n_fail++; $display("FAIL mc_op_count: got %0d want 16", log_opc.size() - b); end
        if (log_opc.size() >= b + 16) begin
            n_checks++; if (log_wdi[b+9] !== 8'h0C) begin n_fail++; $display("FAIL mc_entry2_data: got %h want 0c", log_wdi[b+9]); end
        end
        n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL mc_done_count: got %0d want 1", done_cnt - d0); end
        n_checks++; if (cur_mode !== 2'd1) begin n_fail++; $display("FAIL mc_cur_mode: got %0d want 1", cur_mode); end
    endtask

    task automatic test_mode3();
        int b;
        bit ok;
        b = log_opc.size();
        mode = 2'd3;
        wait_done(400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL m3_done_timeout: got no done want done"); end
        tick(10);
        n_checks++; if (log_opc.size() - b != 16) begin n_fail++; $display("FAIL m3_op_count: got %0d want 16", log_opc.size() - b); end
        if (log_opc.size() >= b + 16) begin
            n_checks++; if (log_wdi[b+1] !== 8'h01) begin n_fail++; $display("FAIL m3_entry0_data: got %h want 01", log_wdi[b+1]); end
            n_checks++; if (log_wdi[b+9] !== 8'h0A) begin n_fail++; $display("FAIL m3_entry2_data: got %h want 0a", log_wdi[b+9]); end
        end
        n_checks++; if (cur_mode !== 2'd0) begin n_fail++; $display("FAIL m3_cur_mode: got %0d want 0", cur_mode); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL m3_no_retrigger: got busy %b want 0", busy); end
    endtask

    task automatic test_readback_fail();
        int b, nw;
        bit ok, got_err;
        b = log_opc.size();
        bad_rd = 1'b1;
        pulse_start();
        got_err = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (error) begin
                got_err = 1'b1;
                break;
            end
        end
        n_checks++; if (!got_err) begin n_fail++; $display("FAIL rb_error_timeout: got no error want error"); end
        tick(2);
        nw = 0;
        for (int k = b; k < log_opc.size(); k++) if (log_opc[k] == 2'b01) nw++;
        n_checks++; if (nw != 4) begin n_fail++; $display("FAIL rb_attempts: got %0d want 4", nw); end
        n_checks++; if (log_opc.size() - b != 16) begin n_fail++; $display("FAIL rb_op_count: got %0d want 16", log_opc.size() - b); end
        n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL rb_error_sticky: got %b want 1", error); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rb_busy: got %b want 0", busy); end
        n_checks++; if (pll_reset !== 1'b0) begin n_fail++; $display("FAIL rb_pll_reset: got %b want 0", pll_reset); end
        bad_rd = 1'b0;
        pulse_start();
        n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL rb_error_clear: got %b want 0", error); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rb_restart_busy: got %b want 1", busy); end
        wait_done(400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rb_recover_done: got no done want done"); end
        tick(2);
    endtask

    task automatic test_timeout();
        int bw, f0;
        bit got_err;
        reset = 1'b1;
        tick(2);
        bw = wins.size();
        f0 = fall2_cnt;
        reset = 1'b0;
        got_err = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            if (error2) begin
                got_err = 1'b1;
                break;
            end
        end
        n_checks++; if (!got_err) begin n_fail++; $display("FAIL to_error_timeout: got no error want error"); end
        tick(2);
        n_checks++; if (fall2_cnt - f0 != 4) begin n_fail++; $display("FAIL to_attempts: got %0d want 4", fall2_cnt - f0); end
        n_checks++; if (wins.size() - bw != 4) begin n_fail++; $display("FAIL to_windows: got %0d want 4", wins.size() - bw); end
        // each low window is the RELEASE cycle plus 50 WAIT_LOCK cycles
        for (int k = bw; k < wins.size(); k++) begin
            n_checks++; if (wins[k] != 51) begin n_fail++; $display("FAIL to_window_len[%0d]: got %0d want 51", k - bw, wins[k]); end
        end
        n_checks++; if (busy2 !== 1'b0) begin n_fail++; $display("FAIL to_busy: got %b want 0", busy2); end
        n_checks++; if (pll_reset2 !== 1'b0) begin n_fail++; $display("FAIL to_pll_reset: got %b want 0", pll_reset2); end
        for (int i = 0; i < 400 && busy; i++) tick(1);
    endtask

    task automatic test_ignore_and_abort();
        int b, b2, b3, w0;
        bit ok, found;
        mode = 2'd0;
        b  = log_opc.size();
        w0 = wr_cnt;
        pulse_start();
        tick(8);
        mode  = 2'd2;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            if (mdopc == 2'b01 && (wr_cnt - w0) == 3) begin
                found = 1'b1;
                break;
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL ab_entry2_write: got none want write"); end
        reset = 1'b1;
        #1;
        n_checks++; if (mdopc !== 2'b00) begin n_fail++; $display("FAIL ab_mdopc: got %b want 00", mdopc); end
        n_checks++; if (pll_reset !== 1'b1) begin n_fail++; $display("FAIL ab_pll_reset: got %b want 1", pll_reset); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ab_busy: got %b want 1", busy); end
        n_checks++; if (log_opc.size() - b != 10) begin n_fail++; $display("FAIL ab_op_count: got %0d want 10", log_opc.size() - b); end
        if (log_opc.size() >= b + 10) begin
            n_checks++; if (log_wdi[b+1] !== 8'h01) begin n_fail++; $display("FAIL ab_entry0_data: got %h want 01", log_wdi[b+1]); end
            n_checks++; if (log_wdi[b+9] !== 8'h0A) begin n_fail++; $display("FAIL ab_entry2_data: got %h want 0a", log_wdi[b+9]); end
        end
        tick(2);
        b2 = log_opc.size();
        reset = 1'b0;
        wait_done(400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ab_restart_done: got no done want done"); end
        n_checks++; if (cur_mode !== 2'd0) begin n_fail++; $display("FAIL ab_restart_mode: got %0d want 0", cur_mode); end
        if (log_opc.size() >= b2 + 16) begin
            n_checks++; if (log_wdi[b2+9] !== 8'h0A) begin n_fail++; $display("FAIL ab_restart_entry2: got %h want 0a", log_wdi[b2+9]); end
        end
        b3 = log_opc.size();
        tick(1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ab_pending_mode: got busy %b want 1", busy); end
        wait_done(400, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL ab_mode2_done: got no done want done"); end
        n_checks++; if (cur_mode !== 2'd2) begin n_fail++; $display("FAIL ab_mode2_cur: got %0d want 2", cur_mode); end
        n_checks++; if (log_opc.size() - b3 != 16) begin n_fail++; $display("FAIL ab_mode2_ops: got %0d want 16", log_opc.size() - b3); end
        if (log_opc.size() >= b3 + 16) begin
            n_checks++; if (log_wdi[b3+1] !== 8'h02) begin n_fail++; $display("FAIL ab_mode2_entry0: got %h want 02", log_wdi[b3+1]); end
            n_checks++; if (log_wdi[b3+9] !== 8'h0E) begin n_fail++; $display("FAIL ab_mode2_entry2: got %h want 0e", log_wdi[b3+9]); end
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_mode_change();
        test_mode3();
        test_readback_fail();
        test_timeout();
        test_ignore_and_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
